// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_t  receiver FSM states (PARITY only exists with UART_RX_PARITY_EN)
//   BAUD_*      supported baud rates, selected by a 2-bit code
//   OVERSAMPLE  ticks per bit period
//   os_div()    clocks per oversample tick for a given clock and rate select
// Optional feature macro: UART_RX_PARITY_EN
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_57600  = 57600;
    localparam int BAUD_115200 = 115200;

    // Clocks per oversample tick, never less than one.
    function automatic int os_div(input int clk_freq, input logic [1:0] sel);
        int baud;
        int div;
        case (sel)
            2'd0:    baud = BAUD_9600;
            2'd1:    baud = BAUD_19200;
            2'd2:    baud = BAUD_57600;
            default: baud = BAUD_115200;
        endcase
        div = clk_freq / (OVERSAMPLE * baud);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: oversample tick generator for the receiver.
//   clk        system clock
//   reset      synchronous active-high reset
//   clear      restarts the divider so ticks align to a detected start edge
//   baud_rate  rate select (already latched by the caller)
//   tick       one-cycle pulse every os_div(CLK_FREQ, baud_rate) clocks
module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] baud_rate,
    output logic       tick
);

    // The slowest rate has the largest divisor, so it sizes the counter.
    localparam int DIV_W = $clog2(os_div(CLK_FREQ, 2'd0)) + 1;

    localparam logic [DIV_W-1:0] DIV_M1_0 = DIV_W'(os_div(CLK_FREQ, 2'd0) - 1);
    localparam logic [DIV_W-1:0] DIV_M1_1 = DIV_W'(os_div(CLK_FREQ, 2'd1) - 1);
    localparam logic [DIV_W-1:0] DIV_M1_2 = DIV_W'(os_div(CLK_FREQ, 2'd2) - 1);
    localparam logic [DIV_W-1:0] DIV_M1_3 = DIV_W'(os_div(CLK_FREQ, 2'd3) - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_m1;

    always_comb begin
        case (baud_rate)
            2'd0:    div_m1 = DIV_M1_0;
            2'd1:    div_m1 = DIV_M1_1;
            2'd2:    div_m1 = DIV_M1_2;
            default: div_m1 = DIV_M1_3;
        endcase
    end

    // No tick in the clear cycle; the first tick lands a full period later.
    assign tick = !clear && (cnt_q == div_m1);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 16x oversampling with mid-bit sampling.
//   clk          system clock
//   reset        synchronous active-high reset
//   baud_rate    0=9600 1=19200 2=57600 3=115200, latched at each start edge
//   rx           asynchronous serial input, idles high
//   data_out     last received byte (held between frames)
//   data_valid   one-cycle strobe, good frame
//   frame_error  one-cycle strobe, stop bit sampled low
//   busy         receiver not idle
//   parity_error one-cycle strobe with data_valid on bad even parity
//                (only with UART_RX_PARITY_EN)
// Optional feature macro: UART_RX_PARITY_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           baud_rate,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);

    localparam int BC_W = $clog2(DATA_BITS + 1);

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_t            state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [1:0]           baud_q, baud_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 clear;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    uart_rx_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .baud_rate (baud_q),
        .tick      (tick)
    );

    // Mid-bit sample points: the 8th tick of the start bit, then every 16th.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        baud_d     = baud_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        clear      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    baud_d     = baud_rate;
                    clear      = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        par_d   = rx_s_q;
                        state_d = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        data_d = shift_q;
                        if (rx_s_q) begin
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = ^shift_q ^ par_q;
`endif
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line must return high before a new start edge counts.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Synchronizer and edge history idle high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            baud_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            baud_q     <= baud_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Serial frames are driven with
// bit timing from the baud table; each frame pushes its expected strobe into
// a queue, and a monitor pops and compares on every strobe.
// Optional feature macro: UART_RX_PARITY_EN
module tb_uart_rx;

    localparam int CLK_FREQ  = 1_843_200;
    localparam int DATA_BITS = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           baud_rate;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_error;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_error;
`endif

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_rate    (baud_rate),
        .rx           (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        bit         parErr;
    } exp_t;

    exp_t expQ[$];
    int   validCycles[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Clocks per bit straight from the rate table.
    function automatic int bitClks(input int sel);
        int rates[4] = '{9600, 19200, 57600, 115200};
        int d;
        d = CLK_FREQ / (16 * rates[sel]);
        if (d < 1) d = 1;
        return 16 * d;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe cycle consumes one expectation.
    always @(negedge clk) begin
        if (!reset && (data_valid || frame_error)) begin
            checkOutput("strobe_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_strobe: got valid=%0b ferr=%0b data=0x%0h, expected none",
                         data_valid, frame_error, data_out);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("strobe_kind", {31'd0, frame_error}, {31'd0, e.isErr});
                checkOutput("data_out", {24'd0, data_out}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
                checkOutput("parity_error", {31'd0, parity_error}, {31'd0, e.parErr});
`endif
            end
            if (data_valid) validCycles.push_back(cyc);
        end
    end

    // One serial frame. rstBit >= 0 pulses reset mid-way through that data
    // bit and expects nothing; lowHold is the stop-bit length in bit times
    // when the stop bit is low.
    task automatic applyStimulus(input logic [7:0] data, input bit stopBit,
                                 input bit parCorrupt, input int sel,
                                 input int rstBit, input int lowHold);
        int   bc;
        exp_t e;
        bc = bitClks(sel);
        baud_rate = 2'(sel);
        if (rstBit < 0) begin
            e.isErr  = !stopBit;
            e.data   = data;
            e.parErr = stopBit && parCorrupt;
            expQ.push_back(e);
        end
        rx = 1'b0;
        hold(bc);
        checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
        // Already latched at the start edge, so this must have no effect.
        baud_rate = 2'($urandom_range(0, 3));
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = data[i];
            if (i == rstBit) begin
                hold(bc / 2);
                checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
                reset = 1'b1;
                hold(1);
                reset = 1'b0;
                checkOutput("rst_data_out", {24'd0, data_out}, 32'd0);
                checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
                checkOutput("rst_ferr", {31'd0, frame_error}, 32'd0);
                checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                hold(bc - bc / 2 - 1);
            end else begin
                hold(bc);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = ^data ^ parCorrupt;
        hold(bc);
`endif
        baud_rate = 2'(sel);
        rx = stopBit;
        if (stopBit) begin
            hold(bc);
        end else begin
            hold(bc * lowHold);
            checkOutput("busy_line_low", {31'd0, busy}, 32'd1);
            rx = 1'b1;
            hold(bc);
        end
        checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        rx        = 1'b1;
        baud_rate = 2'd3;
        hold(3);
        checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
        checkOutput("reset_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("reset_ferr", {31'd0, frame_error}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        hold(4);

        // Fastest rate, single byte.
        applyStimulus(8'hA5, 1'b1, 1'b0, 3, -1, 0);
        hold(5);

        // Slowest rate, back to back with no idle gap.
        applyStimulus(8'h3C, 1'b1, 1'b0, 0, -1, 0);
        applyStimulus(8'hC3, 1'b1, 1'b0, 0, -1, 0);
        hold(2);
        if (validCycles.size() >= 2)
            checkOutput("b2b_spacing",
                        32'(validCycles[validCycles.size()-1] - validCycles[validCycles.size()-2]),
                        32'(160 * 12));
        else
            checkOutput("b2b_count", 32'(validCycles.size()), 32'd3);

        // Short low glitch is rejected at the mid start bit.
        baud_rate = 2'd0;
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(3);
        checkOutput("glitch_busy", {31'd0, busy}, 32'd1);
        hold(8 * 12 + 7);
        checkOutput("glitch_idle", {31'd0, busy}, 32'd0);

        // Framing error followed by a long low line, then a clean frame.
        applyStimulus(8'h55, 1'b0, 1'b0, 1, -1, 50);
        checkOutput("ferr_data_held", {24'd0, data_out}, 32'h55);
        applyStimulus(8'h0F, 1'b1, 1'b0, 1, -1, 0);

        // Reset during bit 4 drops the frame; next frame is clean.
        applyStimulus(8'hFF, 1'b1, 1'b0, 3, 4, 0);
        hold(3);
        applyStimulus(8'h81, 1'b1, 1'b0, 3, -1, 0);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1, 2, -1, 0);
        applyStimulus(8'h07, 1'b1, 1'b0, 2, -1, 0);
`endif

        // Random frames, rates and occasional framing errors.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 4) != 0),
                          1'($urandom), $urandom_range(1, 3), -1,
                          $urandom_range(1, 3));
            hold($urandom_range(0, 20));
        end

        for (int i = 0; i < 4000 && expQ.size() != 0; i++) @(posedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the Tx path and its BaudGen.
- Recovers 8N1 frames from the serial line using 16x oversampling and mid-bit sampling.
- Presents each received byte with a one-cycle valid strobe and a framing-error flag.
- Sits between the external rx pin and the host-side consumer.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- baud_rate  in  2  rate select: 0=9600, 1=19200, 2=57600, 3=115200.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  DATA_BITS  last received byte.
- data_valid  out  1  one-cycle strobe: data_out updated, frame good.
- frame_error  out  1  one-cycle strobe: stop bit sampled low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: data_out=0, data_valid=0, frame_error=0, busy=0, FSM=IDLE, synchronizer flops=1, all counters=0.
- Input sync: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Pin-to-FSM latency is 2 cycles.
- Oversample tick:
  - tick pulses once every OS_DIV clocks; OS_DIV = max(1, floor(CLK_FREQ/(16*baud))).
  - The divider is cleared on start-edge detection, so phase is aligned to the start edge.
  - baud_rate is latched at start detection; changes mid-frame are ignored until the next frame.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a 1->0 transition on rx_s moves to START and clears tick_cnt (4-bit) and the divider.
  - START: at the 8th tick (mid start bit), if rx_s==0 -> DATA with tick_cnt=0 and bit_cnt=0; if rx_s==1 -> IDLE (glitch reject, no strobe).
  - DATA: on every 16th tick, shift rx_s into a shift register at the MSB, shifting right (LSB-first arrival). After DATA_BITS samples -> STOP.
  - STOP: on the 16th tick, sample rx_s.
    - If 1: data_out <= shift register, data_valid=1 for exactly one cycle, next state IDLE.
    - If 0: data_out <= shift register, frame_error=1 for one cycle, next state WAIT_IDLE.
  - WAIT_IDLE: hold until rx_s==1 (break or line-low condition), then IDLE. No new frame is detected while the line stays low.
- Strobe timing: data_valid/frame_error assert in the cycle after the stop-bit sample tick. They are never asserted together.
- Back-to-back frames: a start edge arriving in the first cycle after returning to IDLE must be detected; no dead time beyond 1 cycle.
- Reset mid-frame: the next cycle returns to IDLE, the partial byte is discarded, no strobe is issued.
- data_out holds its value between frames.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - Adds output parity_error (1 bit, reset 0).
  - parity_error pulses together with data_valid when the XOR of the data bits and the parity bit is 1.
  - data_valid still fires for the byte; a frame error takes precedence, and no parity_error is flagged with it.
- Undefined: the frame is 8N1, and neither the port nor the state exists.

Decomposition:
- Package uart_pkg:
  - state enum rx_state_t.
  - baud rate constants BAUD_9600..BAUD_115200 indexed by the 2-bit select.
  - function os_div(clk_freq, sel) returning OS_DIV.
  - constant OVERSAMPLE=16.
- Sub-module uart_rx_tick:
  - Oversample divider with inputs clk, reset, clear, baud_rate; output tick.
  - Mirrors BaudGen's role on the Tx side.

Test Plan (CLK_FREQ=1_843_200, so OS_DIV=1 at baud_rate=3 and 12 at baud_rate=0):
- baud_rate=3, send 0xA5 (8N1, 16 clk/bit) -> one data_valid pulse, data_out=0xA5, frame_error=0, busy high from start to stop.
- baud_rate=0, send 0x3C then 0xC3 back-to-back with no idle gap -> two data_valid pulses 160*12 clocks apart, data_out 0x3C then 0xC3.
- 4-clock low glitch on rx at baud_rate=0 -> no strobes, busy returns to 0 within 8 ticks + 2 cycles.
- Send 0x55 with stop bit forced low, line held low 50 bit times -> frame_error one pulse, data_out=0x55, no new frame until rx high, then 0x0F received cleanly.
- Assert reset for one cycle during bit 4 of 0xFF -> all outputs 0, FSM IDLE, no strobe; next frame 0x81 received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> data_valid plus parity_error; with parity bit 1 -> data_valid only.
